// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline stage with valid/ready handshake, flush, halt latch and
// an optional two-entry skid buffer; also exports the EX bypass forwarding tap.
module ex_mem_pipe #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int SKID       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_rt,
    input  logic [DATA_W-1:0]     in_alu,
    input  logic [REG_ADDR_W-1:0] in_wr_addr,
    input  logic                  in_mem_en,
    input  logic                  in_mem_wr,
    input  logic                  in_halt,
    input  logic                  in_val2reg,
    input  logic                  in_reg_write,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_rt,
    output logic [DATA_W-1:0]     out_alu,
    output logic [REG_ADDR_W-1:0] out_wr_addr,
    output logic                  out_mem_en,
    output logic                  out_mem_wr,
    output logic                  out_halt,
    output logic                  out_val2reg,
    output logic                  out_reg_write,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [1:0]            occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0]     rt;
        logic [DATA_W-1:0]     alu;
        logic [REG_ADDR_W-1:0] wr_addr;
        logic                  mem_en;
        logic                  mem_wr;
        logic                  halt;
        logic                  val2reg;
        logic                  reg_write;
    } entry_t;

    // State encoding is {main_v, skid_v}; 2'b01 is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_TWO   = 2'b11;

    entry_t in_entry;
    entry_t main_q;
    entry_t skid_q;
    logic   main_v;
    logic   skid_v;
    logic   halt_seen;
    logic   accept;
    logic   emit;

    assign in_entry = '{rt: in_rt, alu: in_alu, wr_addr: in_wr_addr,
                        mem_en: in_mem_en, mem_wr: in_mem_wr, halt: in_halt,
                        val2reg: in_val2reg, reg_write: in_reg_write};

    // With the skid entry, in_ready comes straight from flops; without it,
    // a full register can still accept when downstream drains it this cycle.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = !skid_v && !halt_seen;
        end else begin : g_single
            assign in_ready = !halt_seen && (out_ready || !main_v);
        end
    endgenerate

    assign accept = in_valid && in_ready;
    assign emit   = main_v && out_ready;

    // NOTE: every flop here uses non-blocking assignment so that the skid->main
    // move and the new-entry load all sample pre-edge values in one cycle.
    // NOTE: the payload registers are reset too, because the data/address
    // outputs must read 0 after reset rather than hold stale contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q    <= '0;
            skid_q    <= '0;
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            halt_seen <= 1'b0;
        end else if (flush) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            halt_seen <= 1'b0;
        end else begin
            if (accept && in_entry.halt) begin
                halt_seen <= 1'b1;
            end
            case ({main_v, skid_v})
                ST_EMPTY: begin
                    if (accept) begin
                        main_q <= in_entry;
                        main_v <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        main_q <= in_entry;
                    end else if (accept) begin
                        skid_q <= in_entry;
                        skid_v <= 1'b1;
                    end else if (emit) begin
                        main_v <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (emit) begin
                        main_q <= skid_q;
                        skid_v <= 1'b0;
                    end
                end
                default: begin
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid     = main_v;
    assign out_rt        = main_q.rt;
    assign out_alu       = main_q.alu;
    assign out_wr_addr   = main_q.wr_addr;
    assign out_val2reg   = main_q.val2reg;
    assign out_mem_en    = main_v && main_q.mem_en;
    assign out_mem_wr    = main_v && main_q.mem_wr;
    assign out_halt      = main_v && main_q.halt;
    assign out_reg_write = main_v && main_q.reg_write;

    assign fwd_valid = out_valid && out_reg_write;
    assign fwd_addr  = out_wr_addr;
    assign fwd_data  = out_alu;

    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
Parametrised EX→MEM pipeline stage for the next-generation core. It replaces the fixed-width, always-advancing EX/MEM flop bank with a valid/ready stage that can absorb downstream stalls and honour flushes. An optional skid buffer keeps in_ready registered, with no combinational path from out_ready. The stage also exports a forwarding tap for the EX bypass network.

Parameters:
DATA_W, 16, width of rt and alu data fields
REG_ADDR_W, 3, width of writeback register address
SKID, 1, 1 = two-entry skid stage with registered in_ready; 0 = single register with combinational in_ready

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  EX presents an entry
in_ready  out  1  stage can accept an entry
in_rt  in  DATA_W  store data
in_alu  in  DATA_W  ALU result / address
in_wr_addr  in  REG_ADDR_W  writeback register
in_mem_en, in_mem_wr, in_halt  in  1 each  MEM control
in_val2reg, in_reg_write  in  1 each  WB control
out_valid  out  1  MEM-facing entry valid
out_ready  in  1  MEM consumes entry
out_rt, out_alu  out  DATA_W each  held data
out_wr_addr  out  REG_ADDR_W
out_mem_en, out_mem_wr, out_halt, out_val2reg, out_reg_write  out  1 each
fwd_valid  out  1  out_valid & out_reg_write
fwd_addr  out  REG_ADDR_W  = out_wr_addr
fwd_data  out  DATA_W  = out_alu
occupancy  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Reset (rst low, async): all valids 0, all data/addr 0, halt_seen 0, occupancy 0. in_ready reads 1, but no transfer occurs while rst is low.
- Accept: in_valid & in_ready at rising edge. Emit: out_valid & out_ready at rising edge. Latency: an accepted entry appears on out_* at the next edge when the stage is empty.
- Control gating: when out_valid=0, out_mem_en, out_mem_wr, out_halt and out_reg_write read 0. Data fields hold their last value.
- SKID=1 FSM on {main_v, skid_v}:
  - EMPTY: accept → ONE (load main).
  - ONE: accept & !emit → TWO (load skid). Emit & !accept → EMPTY. Accept & emit → ONE (main ← input).
  - TWO: emit → ONE (main ← skid; skid cleared). Accept is impossible in TWO.
  - in_ready = !skid_v & !halt_seen, taken directly from flops.
- SKID=0: one register. in_ready = !halt_seen & (out_ready | !out_valid). Accept and emit in the same cycle replaces the entry.
- Halt: accepting an entry with in_halt=1 sets halt_seen. in_ready stays 0 until flush or reset. The halt entry and any older entries still drain normally.
- Flush (edge with flush=1): clears main_v, skid_v and halt_seen.
  - Any entry accepted in the same cycle is discarded.
  - An emit in the same cycle still counts as consumed downstream; the stage itself ends empty.
  - in_ready=1 on the following cycle.
- Data stability: out_* do not change while out_valid=1 & out_ready=0, except through flush.
- occupancy = main_v + skid_v.

Test Plan:
- Reset & pass-through: release rst; in_valid=1 for 3 cycles with alu=0x0011, 0x0022, 0x0033 and out_ready=1 → out_alu shows each value 1 cycle later, out_valid=1 for 3 cycles, occupancy ≤1.
- Stall fill (SKID=1): out_ready=0, push alu=0xA001 then 0xA002 → occupancy=2, in_ready=0 on the third cycle, out_alu stays 0xA001. Release out_ready → 0xA001 then 0xA002 emitted in order, with no loss or duplicate.
- Flush with concurrent accept: occupancy=2, then flush=1 with in_valid=1 and alu=0xBEEF → next cycle out_valid=0, occupancy=0, in_ready=1, and 0xBEEF never appears.
- Halt: accept an entry with in_halt=1 and alu=0x0042 → in_ready=0 from the next cycle; out_halt=1 with out_valid=1; later in_valid pulses are ignored until flush.
- Forwarding tap: entry with reg_write=1, wr_addr=5, alu=0x1234 → fwd_valid=1, fwd_addr=5, fwd_data=0x1234; with reg_write=0 → fwd_valid=0.
- Async reset mid-stall: assert rst low between edges with occupancy=2 → out_valid drops to 0 immediately, before the next clock edge; after release, occupancy=0 and in_ready=1.
